imm_unit: RTL

IMM_UNIT -- requirements
Module: imm_unit

---
 rtl/imm_unit_pkg.sv | 22 ++
 rtl/imm_unit_gen.sv | 48 ++++
 rtl/imm_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/imm_unit_pkg.sv
// rtl/imm_unit_pkg.sv - shared CPU package: immediate mode encodings and shift-amount width
// Purpose: mode encodings used by imm_gen/imm_unit and the SHAMT field width derivation.
// Ports: none (package).
package imm_unit_pkg;

  localparam int IMM_MODE_W = 3;

  typedef enum logic [IMM_MODE_W-1:0] {
    IMM_SEXT16 = 3'd0,
    IMM_ZEXT16 = 3'd1,
    IMM_SHAMT  = 3'd2,
    IMM_UPPER  = 3'd3,
    IMM_CONST  = 3'd4,
    IMM_BROFF  = 3'd5
  } imm_mode_e;

  // Shift-amount field is 5 bits on a 32-bit datapath, 6 bits on a 64-bit one.
  function automatic int imm_shamt_width(input int xlen);
    return (xlen == 64) ? 6 : 5;
  endfunction

endpackage

// File: rtl/imm_unit_gen.sv
// rtl/imm_unit_gen.sv - combinational immediate decode/extension
// Purpose: turns an instruction word and mode select into an XLEN-bit immediate.
// Ports:
//   ir      in  32    instruction word
//   mode    in  3     immediate mode select
//   imm     out XLEN  generated immediate (0 for modes 6/7)
//   illegal out 1     mode is not one of the defined encodings
module imm_gen
  import imm_unit_pkg::*;
#(
  parameter int          XLEN          = 32,
  parameter logic [63:0] DEFAULT_CONST = 64'd10
) (
  input  logic [31:0]           ir,
  input  logic [IMM_MODE_W-1:0] mode,
  output logic [XLEN-1:0]       imm,
  output logic                  illegal
);

  localparam int SW = imm_shamt_width(XLEN);

  logic [XLEN-1:0] sext16;
  logic [XLEN-1:0] shamt_v;

  always_comb begin
    // Sign-extended halfword is the base for UPPER and BROFF too, so their
    // upper bits come out correctly sign-extended at the full XLEN width.
    sext16 = {{(XLEN-16){ir[15]}}, ir[15:0]};
    shamt_v = '0;
    shamt_v[SW-1:0] = ir[6+SW-1:6];

    imm     = '0;
    illegal = 1'b0;
    case (mode)
      IMM_SEXT16: imm = sext16;
      IMM_ZEXT16: imm = {{(XLEN-16){1'b0}}, ir[15:0]};
      IMM_SHAMT:  imm = shamt_v;
      IMM_UPPER:  imm = sext16 << 16;
      IMM_CONST:  imm = DEFAULT_CONST[XLEN-1:0];
      IMM_BROFF:  imm = sext16 << 2;
      default: begin
        imm     = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_unit.sv
// rtl/imm_unit.sv - immediate generator with a 2-entry skid buffer on its output
// Purpose: accepts ir/mode, generates the immediate, presents it one cycle later.
// Ports:
//   clk       in  1     rising-edge clock
//   rst_n     in  1     asynchronous active-low reset
//   in_valid  in  1     ir/mode valid
//   in_ready  out 1     input accepted this cycle (registered, = no skid entry)
//   ir        in  32    instruction word
//   mode      in  3     immediate mode select
//   flush     in  1     drop held entries and this cycle's input
//   out_valid out 1     out_imm valid
//   out_ready in  1     consumer accepts out_imm
//   out_imm   out XLEN  generated immediate
//   err       out 1     sticky illegal-mode flag
module imm_unit
  import imm_unit_pkg::*;
#(
  parameter int          XLEN          = 32,
  parameter logic [63:0] DEFAULT_CONST = 64'd10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           ir,
  input  logic [IMM_MODE_W-1:0] mode,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_imm,
  output logic                  err
);

  logic [XLEN-1:0] gen_imm;
  logic            gen_illegal;

  logic            main_valid_q, main_valid_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic            err_q, err_d;

  logic accept;
  logic drain;

  imm_gen #(
    .XLEN          (XLEN),
    .DEFAULT_CONST (DEFAULT_CONST)
  ) u_gen (
    .ir      (ir),
    .mode    (mode),
    .imm     (gen_imm),
    .illegal (gen_illegal)
  );

  always_comb begin
    accept = in_valid && !skid_valid_q && !flush;
    drain  = main_valid_q && out_ready;

    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    err_d        = err_q | (accept && gen_illegal);

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      // Main slot frees up: the older skid entry has priority. accept is
      // impossible while skid is occupied, so nothing can be lost here.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_imm_d = gen_imm;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = gen_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      err_q        <= err_d;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_imm   = main_imm_q;
  assign err       = err_q;

endmodule
